coin_input_cond: RTL and testbench
==================================

# coin_input_cond

Input conditioning stage between the keyboard/joystick merge logic and the game core's `INP` port. It synchronises and debounces every active-high control bit and converts each coin contact into clean, fixed-width, rate-limited coin pulses. Bursts of up to three coin presses are queued per channel. The result is driven as the core's active-low 11-bit input vector.

## Interface

Parameters:
- `CLK_HZ`, 48000000: `clk_sys` frequency in Hz. The tick divider is `TICK_DIV = CLK_HZ/1000`.
- `DEB_MS`, 8: debounce stability time in ms ticks, range 1..15.
- `COIN_MS`, 50: coin pulse width in ms ticks, range 1..255.
- `GAP_MS`, 50: minimum inactive time after each coin pulse, in ms ticks, range 1..255.

Ports:
- `clk_sys` in 1: single clock. All logic runs on its rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `IN` in 11: raw active-high controls {SELFT, COIN2, COIN1, P2LF, P2RG, P2DW, P2RO, P1LF, P1RG, P1DW, P1RO}, bit 10 down to bit 0. Asynchronous to `clk_sys`.
- `INP` out 11: registered, active-low conditioned vector in the same bit order. Feeds the core's `INP`.
- `TICK` out 1: one-cycle 1 ms strobe.
- `COIN_OVF` out 2: one-cycle pulse when a coin press is dropped. Bit 1 is COIN2, bit 0 is COIN1.

## Operation

**Reset values** (all asynchronous on `reset_n` low):
- `INP` = 11'h7FF, `TICK` = 0, `COIN_OVF` = 0.
- Synchronisers, debounced state and debounce counters = 0.
- Coin FSMs = IDLE, pending counts = 0, timers = 0.

**Synchronise**
- Two-flop synchroniser on every `IN` bit.

**Tick**
- Counter runs 0..`TICK_DIV`-1.
- `TICK` = 1 in the cycle the counter equals `TICK_DIV`-1, then the counter wraps to 0.
- The tick is free-running. It is never restarted by input events.

**Debounce** (per bit, 4-bit counter)
- If synced input == debounced state: counter cleared.
- Otherwise, on each `TICK`: counter increments.
  - When the increment would reach `DEB_MS`, the debounced state flips and the counter clears in the same cycle.
- Any return to equality before that discards the accumulated count.

**Non-coin bits** (SELFT, joystick, rotate)
- `INP[i]` = ~debounced[i], registered.

**Coin channels** (two independent copies)
- A rising edge of the debounced coin bit is a *press*.
- Pending count: 2 bits, saturating at 3.

FSM states:
- **IDLE**
  - Press this cycle, or pending > 0 → PULSE, timer = 0.
  - If the exit was caused by pending and not by a press: pending decrements.
  - A press in IDLE with pending = 0 is consumed directly; pending is unchanged.
- **PULSE**: on each `TICK`, timer++. When timer reaches `COIN_MS` → GAP, timer = 0.
- **GAP**: on each `TICK`, timer++. When timer reaches `GAP_MS` → IDLE.

Pending rules:
- A press in PULSE or GAP increments pending.
- A press at pending = 3 is dropped and `COIN_OVF[ch]` pulses for one cycle.
- A press in the same cycle IDLE consumes a pending coin: the press is counted and the decrement applied, so the net change is 0.

Output:
- `INP` coin bit = 0 exactly while the FSM is in PULSE, delayed by the output register.

Reset mid-operation:
- Pending coins are discarded.
- Any active pulse ends immediately (`INP` = 7FF asynchronously).

## Timing

Non-coin path:
- `IN` edge to `INP` change = 2 sync cycles + debounce + 1 output register.
- Debounce delay is between `DEB_MS`-1 and `DEB_MS` ms, because the first tick is partial.

Coin path:
- Press detected at cycle N: FSM is in PULSE at N+1, `INP` coin bit is low at N+2.

Pulse and gap widths:
- Coin low width is `COIN_MS`-1 to `COIN_MS` ms, because the first tick is partial.
- Gap is `GAP_MS`-1 to `GAP_MS` ms.
- Back-to-back queued pulses are separated by at least the gap plus 1 cycle (the IDLE visit).

`COIN_OVF` is registered and asserts the cycle after the dropped press.

## Test plan

Bench parameters: `CLK_HZ`=10000 (tick every 10 cycles), `DEB_MS`=4, `COIN_MS`=40, `GAP_MS`=20.

1. Reset, inputs all 0 → `INP`=7FF, `COIN_OVF`=0, first `TICK` at cycle 10 after release, then every 10 cycles.
2. P1RO high for 25 cycles → `INP[0]` stays 1. P1RO held for 80 cycles → `INP[0]` goes 0 between 33 and 43 cycles after the edge. Release held for 80 cycles → `INP[0]` returns to 1.
3. COIN1 high for 100 cycles → `INP[8]` low exactly once, for 391–400 cycles. No second pulse within 2000 cycles.
4. Five COIN1 presses (50 high / 50 low each) → exactly 4 pulses on `INP[8]`, each ≥390 cycles low, with ≥191 high cycles between pulses; `COIN_OVF[0]` pulses once, `COIN_OVF[1]` never.
5. COIN1 and COIN2 pressed simultaneously for 100 cycles → `INP[8]` and `INP[9]` pulse concurrently with identical widths; other bits stay 1.
6. Two queued presses, then `reset_n` low mid-PULSE → `INP`=7FF in the same cycle. After release, with inputs idle, no pulses for 2000 cycles.

Source files
------------

// File: rtl/coin_input_cond.sv
// Input conditioning for the game core: synchronise and debounce the active-high
// controls, turn coin contacts into queued, fixed-width, rate-limited coin pulses.
module coin_input_cond #(
    parameter int CLK_HZ  = 48000000,
    parameter int DEB_MS  = 8,
    parameter int COIN_MS = 50,
    parameter int GAP_MS  = 50
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] IN,
    output logic [10:0] INP,
    output logic        TICK,
    output logic [1:0]  COIN_OVF
);
    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP
    } coin_st_t;

    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;
    logic [10:0]   r_sync1;
    logic [10:0]   r_sync2;
    logic [10:0]   r_deb;
    logic [3:0]    r_deb_cnt [11];
    logic [1:0]    r_coin_q;
    logic [1:0]    w_press;
    coin_st_t      r_state   [2];
    logic [1:0]    r_pend    [2];
    logic [7:0]    r_timer   [2];
    logic [1:0]    r_ovf;
    logic [10:0]   r_inp;

    // Free-running 1 ms strobe; input activity never restarts it.
    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // NOTE: the per-bit counter array is reset element by element in a loop; it is a
    // handful of flops, not a RAM, so it must come out of reset in a known state.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_deb    <= '0;
            r_coin_q <= '0;
            for (int i = 0; i < 11; i++) r_deb_cnt[i] <= '0;
        end else begin
            r_sync1  <= IN;
            r_sync2  <= r_sync1;
            r_coin_q <= r_deb[9:8];
            for (int i = 0; i < 11; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (w_tick) begin
                    if (r_deb_cnt[i] == 4'(DEB_MS - 1)) begin
                        r_deb[i]     <= ~r_deb[i];
                        r_deb_cnt[i] <= '0;
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign w_press = r_deb[9:8] & ~r_coin_q;

    // NOTE: all sequential state uses non-blocking assignments so every channel sees
    // the pre-edge values of r_state/r_pend regardless of statement order.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= '0;
            for (int ch = 0; ch < 2; ch++) begin
                r_state[ch] <= ST_IDLE;
                r_pend[ch]  <= '0;
                r_timer[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                r_ovf[ch] <= 1'b0;
                case (r_state[ch])
                    ST_IDLE: begin
                        if (w_press[ch] || (r_pend[ch] != 2'd0)) begin
                            r_state[ch] <= ST_PULSE;
                            r_timer[ch] <= '0;
                            // A press arriving with a queued coin replaces the one taken.
                            if (!w_press[ch]) r_pend[ch] <= r_pend[ch] - 1'b1;
                        end
                    end
                    ST_PULSE: begin
                        if (w_tick) begin
                            if (r_timer[ch] == 8'(COIN_MS - 1)) begin
                                r_state[ch] <= ST_GAP;
                                r_timer[ch] <= '0;
                            end else begin
                                r_timer[ch] <= r_timer[ch] + 1'b1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (w_tick) begin
                            if (r_timer[ch] == 8'(GAP_MS - 1)) begin
                                r_state[ch] <= ST_IDLE;
                                r_timer[ch] <= '0;
                            end else begin
                                r_timer[ch] <= r_timer[ch] + 1'b1;
                            end
                        end
                    end
                    default: r_state[ch] <= ST_IDLE;
                endcase

                if ((r_state[ch] != ST_IDLE) && w_press[ch]) begin
                    if (r_pend[ch] == 2'd3) begin
                        r_ovf[ch] <= 1'b1;
                    end else begin
                        r_pend[ch] <= r_pend[ch] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_inp <= 11'h7FF;
        end else begin
            r_inp[7:0] <= ~r_deb[7:0];
            r_inp[8]   <= (r_state[0] != ST_PULSE);
            r_inp[9]   <= (r_state[1] != ST_PULSE);
            r_inp[10]  <= ~r_deb[10];
        end
    end

    assign INP      = r_inp;
    assign TICK     = w_tick;
    assign COIN_OVF = r_ovf;

endmodule

// File: tb/tb_coin_input_cond.sv
// Bench for coin_input_cond: timestamp-based reference model predicts every output
// edge into per-bit queues; a monitor pops and compares as the DUT outputs move.
module tb_coin_input_cond;
    localparam int CLK_HZ  = 10000;
    localparam int DEB_MS  = 4;
    localparam int COIN_MS = 40;
    localparam int GAP_MS  = 20;
    localparam int TDIV    = CLK_HZ / 1000;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] IN      = '0;
    logic [10:0] INP;
    logic        TICK;
    logic [1:0]  COIN_OVF;

    coin_input_cond #(
        .CLK_HZ (CLK_HZ),
        .DEB_MS (DEB_MS),
        .COIN_MS(COIN_MS),
        .GAP_MS (GAP_MS)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .IN      (IN),
        .INP     (INP),
        .TICK    (TICK),
        .COIN_OVF(COIN_OVF)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Cycles since reset release; cycle c is the interval after the c-th rising edge.
    int tr;
    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) tr <= 0;
        else          tr <= tr + 1;
    end

    typedef struct {
        int   cyc;
        logic val;
    } ev_t;

    ev_t inp_q [11][$];
    int  ovf_q [2][$];

    // Reference model state: debounced levels plus timestamps, not per-cycle counters.
    logic [10:0] m_deb, m_deb_prev, m_h1, m_h2;
    int          m_dstart   [11];
    int          m_busy_end [2];
    int          m_pend     [2];

    function automatic int nth_tick(input int x, input int n);
        return x + (((TDIV - 1) - (x % TDIV) + TDIV) % TDIV) + (n - 1) * TDIV;
    endfunction

    task automatic push_ev(input int b, input int cyc, input logic v);
        ev_t e;
        e.cyc = cyc;
        e.val = v;
        inp_q[b].push_back(e);
    endtask

    task automatic model_reset();
        m_deb = '0; m_deb_prev = '0; m_h1 = '0; m_h2 = '0;
        for (int i = 0; i < 11; i++) begin
            m_dstart[i] = -1;
            inp_q[i].delete();
        end
        for (int ch = 0; ch < 2; ch++) begin
            m_busy_end[ch] = -1;
            m_pend[ch]     = 0;
            ovf_q[ch].delete();
        end
    endtask

    task automatic model_step(input int c, input logic [10:0] in_now);
        logic [10:0] s;
        logic        p;
        int          st, e, g;
        s    = m_h2;
        m_h2 = m_h1;
        m_h1 = in_now;
        for (int ch = 0; ch < 2; ch++) begin
            p = m_deb[8+ch] & ~m_deb_prev[8+ch];
            if (c > m_busy_end[ch]) begin
                if (p || m_pend[ch] > 0) begin
                    if (!p) m_pend[ch]--;
                    st = c + 1;
                    e  = nth_tick(st, COIN_MS);
                    g  = nth_tick(e + 1, GAP_MS);
                    push_ev(8 + ch, st + 1, 1'b0);
                    push_ev(8 + ch, e + 2, 1'b1);
                    m_busy_end[ch] = g;
                end
            end else if (p) begin
                if (m_pend[ch] == 3) ovf_q[ch].push_back(c + 1);
                else                 m_pend[ch]++;
            end
        end
        m_deb_prev = m_deb;
        // A bit flips on the DEB_MS-th tick after its synced value starts disagreeing.
        for (int i = 0; i < 11; i++) begin
            if (s[i] == m_deb[i]) begin
                m_dstart[i] = -1;
            end else begin
                if (m_dstart[i] < 0) m_dstart[i] = c;
                if (c == nth_tick(m_dstart[i], DEB_MS)) begin
                    m_deb[i]    = ~m_deb[i];
                    m_dstart[i] = -1;
                    if (i != 8 && i != 9) push_ev(i, c + 2, ~m_deb[i]);
                end
            end
        end
    endtask

    task automatic drive(input logic [10:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            IN = v;
            model_step(tr, v);
            @(negedge clk_sys);
        end
    endtask

    logic [10:0] prev_inp = 11'h7FF;
    int first_tick = -1;
    int low_start  [2] = '{-1, -1};
    int last_rise  [2] = '{-1, -1};
    int width_last [2] = '{0, 0};
    int min_width  [2] = '{1000000, 1000000};
    int max_width  [2] = '{0, 0};
    int min_gap    [2] = '{1000000, 1000000};
    int n_pulse    [2] = '{0, 0};
    int n_ovf      [2] = '{0, 0};

    always @(negedge clk_sys) begin
        ev_t e;
        int  w, ch;
        logic exp_tick;
        if (!reset_n) begin
            prev_inp  = 11'h7FF;
            low_start = '{-1, -1};
            last_rise = '{-1, -1};
        end else begin
            exp_tick = ((tr % TDIV) == TDIV - 1);
            if (TICK || exp_tick) check("tick", TICK, exp_tick);
            if (TICK && first_tick < 0) first_tick = tr;
            for (int b = 0; b < 11; b++) begin
                if (INP[b] !== prev_inp[b]) begin
                    if (inp_q[b].size() == 0) begin
                        check($sformatf("inp%0d_spurious", b), INP[b], prev_inp[b]);
                    end else begin
                        e = inp_q[b].pop_front();
                        check($sformatf("inp%0d_cycle", b), tr, e.cyc);
                        check($sformatf("inp%0d_value", b), INP[b], e.val);
                    end
                    if (b == 8 || b == 9) begin
                        ch = b - 8;
                        if (INP[b] == 1'b0) begin
                            low_start[ch] = tr;
                            if (last_rise[ch] >= 0 && tr - last_rise[ch] < min_gap[ch])
                                min_gap[ch] = tr - last_rise[ch];
                        end else if (low_start[ch] >= 0) begin
                            w = tr - low_start[ch];
                            width_last[ch] = w;
                            n_pulse[ch]++;
                            if (w < min_width[ch]) min_width[ch] = w;
                            if (w > max_width[ch]) max_width[ch] = w;
                            last_rise[ch] = tr;
                        end
                    end
                end
            end
            for (int c2 = 0; c2 < 2; c2++) begin
                if (COIN_OVF[c2]) begin
                    n_ovf[c2]++;
                    if (ovf_q[c2].size() == 0) check($sformatf("ovf%0d_spurious", c2), 1, 0);
                    else check($sformatf("ovf%0d_cycle", c2), tr, ovf_q[c2].pop_front());
                end
            end
            prev_inp = INP;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int np0, np1, no0, no1;
        logic [10:0] cur;
        model_reset();
        repeat (3) @(negedge clk_sys);
        #1;
        check("rst_inp", INP, 11'h7FF);
        check("rst_tick", TICK, 1'b0);
        check("rst_ovf", COIN_OVF, 2'b00);
        @(negedge clk_sys);
        reset_n = 1'b1;

        drive('0, 30);
        check("first_tick_cycle", first_tick, TDIV - 1);

        // Debounce on P1RO: short glitch rejected, long hold accepted and released.
        drive(11'h001, 25);
        drive('0, 20);
        check("p1ro_glitch", INP[0], 1'b1);
        drive(11'h001, 80);
        check("p1ro_held", INP[0], 1'b0);
        drive('0, 80);
        check("p1ro_released", INP[0], 1'b1);

        // Single coin press.
        np0 = n_pulse[0];
        drive(11'h100, 100);
        drive('0, 2000);
        check("coin1_single_count", n_pulse[0] - np0, 1);
        check("coin1_width_in_range", (width_last[0] >= 391 && width_last[0] <= 400), 1);

        // Five presses: three queue, the fifth overflows.
        np0 = n_pulse[0]; no0 = n_ovf[0]; no1 = n_ovf[1];
        min_width[0] = 1000000; min_gap[0] = 1000000; last_rise[0] = -1;
        for (int k = 0; k < 5; k++) begin
            drive(11'h100, 50);
            drive('0, 50);
        end
        drive('0, 2600);
        check("burst_pulse_count", n_pulse[0] - np0, 4);
        check("burst_ovf0_count", n_ovf[0] - no0, 1);
        check("burst_ovf1_count", n_ovf[1] - no1, 0);
        check("burst_min_width", min_width[0] >= 390, 1);
        check("burst_min_gap", min_gap[0] >= 191, 1);

        // Both coins together.
        np0 = n_pulse[0]; np1 = n_pulse[1];
        drive(11'h300, 100);
        drive('0, 700);
        check("dual_coin1_count", n_pulse[0] - np0, 1);
        check("dual_coin2_count", n_pulse[1] - np1, 1);
        check("dual_width_equal", width_last[1], width_last[0]);
        check("dual_others_idle", INP, 11'h7FF);

        // Queue two coins, then reset in the middle of the first pulse.
        for (int k = 0; k < 3; k++) begin
            drive(11'h100, 50);
            drive('0, 50);
        end
        drive('0, 50);
        check("pre_reset_pulse_low", INP[8], 1'b0);
        reset_n = 1'b0;
        #1;
        check("midrst_inp", INP, 11'h7FF);
        model_reset();
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        np0 = n_pulse[0];
        drive('0, 2000);
        check("post_reset_no_pulse", n_pulse[0] - np0, 0);
        check("post_reset_inp_idle", INP, 11'h7FF);

        // Random toggling of one or two bits with random hold times.
        cur = '0;
        for (int k = 0; k < 120; k++) begin
            cur = cur ^ 11'(1 << $urandom_range(0, 10));
            if ($urandom_range(0, 3) == 0) cur = cur ^ 11'(1 << $urandom_range(0, 10));
            drive(cur, $urandom_range(1, 70));
        end
        drive('0, 4000);

        for (int b = 0; b < 11; b++) check($sformatf("inp%0d_queue_drained", b), inp_q[b].size(), 0);
        for (int c2 = 0; c2 < 2; c2++) check($sformatf("ovf%0d_queue_drained", c2), ovf_q[c2].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
